// File: rtl/store_checker_dmem.sv
// store_checker_dmem: word-organised data RAM for the core's load/store port,
// with an in-hardware checker that watches the store stream and latches a
// sticky PASS/FAIL verdict so self-test programs can be judged on the board.
module store_checker_dmem #(
  parameter int          DEPTH        = 64,
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAddress,
  input  logic [31:0]      WriteData,
  input  logic [1:0]       AccessSize,
  input  logic             LoadUnsigned,
  output logic [31:0]      ReadData,
  output logic             done,
  output logic             pass,
  output logic             misaligned,
  output logic [CNT_W-1:0] store_count
);

  localparam int          AW         = $clog2(4 * DEPTH);
  localparam logic [31:0] BYTES      = 32'(4 * DEPTH);
  // The checker matches addresses at word granularity, so a narrow store to
  // any byte of the scratch or pass word is treated as a store to that word.
  localparam logic [29:0] PASS_WORD    = PASS_ADDR[31:2];
  localparam logic [29:0] SCRATCH_WORD = SCRATCH_ADDR[31:2];

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  logic [31:0]      mem [DEPTH];

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [AW-3:0]    word_idx;
  logic             in_range;
  logic             is_word;
  logic             is_misaligned;
  logic             at_pass;
  logic             at_scratch;
  logic [3:0]       byte_en;
  logic [31:0]      lane_data;
  logic             ram_we;
  logic [31:0]      rd_word;

  assign word_idx      = DataAddress[AW-1:2];
  assign in_range      = (DataAddress < BYTES);
  assign is_word       = AccessSize[1];  // 10 word, 11 reserved -> word
  assign is_misaligned = (AccessSize == 2'b01 && DataAddress[0]) ||
                         (is_word && DataAddress[1:0] != 2'b00);
  assign at_pass       = (DataAddress[31:2] == PASS_WORD);
  assign at_scratch    = (DataAddress[31:2] == SCRATCH_WORD);

  // Byte-lane enables and lane-replicated store data for narrow stores
  always_comb begin
    byte_en   = 4'b1111;
    lane_data = WriteData;
    case (AccessSize)
      2'b00: begin
        byte_en   = 4'b0001 << DataAddress[1:0];
        lane_data = {4{WriteData[7:0]}};
      end
      2'b01: begin
        byte_en   = DataAddress[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{WriteData[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        lane_data = WriteData;
      end
    endcase
  end

  // RAM is only written while running; reset low at the edge blocks the write
  assign ram_we = MemWrite && (state_q == ST_RUN) && !is_misaligned &&
                  in_range && reset;

  // Byte-enabled RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
      end
    end
  end

  // Combinational load: old word until the edge, lane select and extension
  always_comb begin
    rd_word  = in_range ? mem[word_idx] : 32'd0;
    ReadData = rd_word;
    case (AccessSize)
      2'b00: begin
        logic [7:0] b;
        b        = rd_word[DataAddress[1:0]*8 +: 8];
        ReadData = LoadUnsigned ? {24'd0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        logic [15:0] h;
        h        = DataAddress[1] ? rd_word[31:16] : rd_word[15:0];
        ReadData = LoadUnsigned ? {16'd0, h} : {{16{h[15]}}, h};
      end
      default: ReadData = rd_word;
    endcase
  end

  // Store checker next state: priority misaligned > pass word > scratch > other
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    pass_d  = pass_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (state_q == ST_RUN && MemWrite) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      if (is_misaligned) begin
        state_d = ST_FAIL;
        done_d  = 1'b1;
        mis_d   = 1'b1;
      end else if (at_pass) begin
        done_d = 1'b1;
        if (is_word && WriteData == PASS_DATA) begin
          state_d = ST_PASS;
          pass_d  = 1'b1;
        end else begin
          state_d = ST_FAIL;
        end
      end else if (!at_scratch) begin
        state_d = ST_FAIL;
        done_d  = 1'b1;
      end
    end
  end

  // Checker state and registered verdict outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign misaligned  = mis_q;
  assign store_count = cnt_q;

endmodule

// File: tb/tb_store_checker_dmem.sv
// tb_store_checker_dmem: directed store/load sequences for store_checker_dmem
// with hand-computed expected values.
module tb_store_checker_dmem;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAddress;
  logic [31:0] WriteData;
  logic [1:0]  AccessSize;
  logic        LoadUnsigned;
  logic [31:0] ReadData;
  logic        done;
  logic        pass;
  logic        misaligned;
  logic [15:0] store_count;

  int checks = 0;
  int errors = 0;

  store_checker_dmem dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .DataAddress  (DataAddress),
    .WriteData    (WriteData),
    .AccessSize   (AccessSize),
    .LoadUnsigned (LoadUnsigned),
    .ReadData     (ReadData),
    .done         (done),
    .pass         (pass),
    .misaligned   (misaligned),
    .store_count  (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    MemWrite = 1'b0;
    reset    = 1'b0;
    #2;
    reset    = 1'b1;
    $display("reset pulse");
  endtask

  // One store: drive on the falling edge, return 1 time unit after the rising edge
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
    @(negedge clk);
    MemWrite    = 1'b1;
    DataAddress = addr;
    WriteData   = data;
    AccessSize  = sz;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    $display("store addr=%0d data=%h size=%0d -> done=%0b pass=%0b mis=%0b cnt=%0d",
             addr, data, sz, done, pass, misaligned, store_count);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] exp);
    MemWrite     = 1'b0;
    DataAddress  = addr;
    AccessSize   = sz;
    LoadUnsigned = uns;
    #1;
    $display("load addr=%0d size=%0d uns=%0b -> %h", addr, sz, uns, ReadData);
    chk(tag, ReadData, exp);
  endtask

  task automatic chk_status(input string tag, input logic d, input logic p,
                            input logic m, input logic [15:0] c);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
    chk({tag, "_mis"},  {31'd0, misaligned}, {31'd0, m});
    chk({tag, "_cnt"},  {16'd0, store_count}, {16'd0, c});
  endtask

  initial begin
    reset        = 1'b0;
    MemWrite     = 1'b0;
    DataAddress  = '0;
    WriteData    = '0;
    AccessSize   = 2'b10;
    LoadUnsigned = 1'b0;
    #12;
    reset = 1'b1;
    chk_status("rst", 1'b0, 1'b0, 1'b0, 16'd0);

    // T1: scratch store then pass store
    do_store(32'd96, 32'd7, 2'b10);
    chk_status("t1a", 1'b0, 1'b0, 1'b0, 16'd1);
    do_store(32'd100, 32'd25, 2'b10);
    chk_status("t1b", 1'b1, 1'b1, 1'b0, 16'd2);
    do_read("t1_rd100", 32'd100, 2'b10, 1'b0, 32'd25);
    do_read("t1_rd96", 32'd96, 2'b10, 1'b0, 32'd7);

    // T2: wrong pass data, then frozen
    do_reset();
    do_store(32'd100, 32'd24, 2'b10);
    chk_status("t2a", 1'b1, 1'b0, 1'b0, 16'd1);
    do_read("t2_rd100", 32'd100, 2'b10, 1'b0, 32'd24);
    do_store(32'd96, 32'd5, 2'b10);
    chk_status("t2b", 1'b1, 1'b0, 1'b0, 16'd1);
    do_read("t2_frozen96", 32'd96, 2'b10, 1'b0, 32'd7);

    // T3: misaligned word store
    do_reset();
    do_store(32'd98, 32'd25, 2'b10);
    chk_status("t3", 1'b1, 1'b0, 1'b1, 16'd1);
    do_read("t3_rd96", 32'd96, 2'b10, 1'b0, 32'd7);

    // Misaligned half store
    do_reset();
    do_store(32'd97, 32'h1234, 2'b01);
    chk_status("mhalf", 1'b1, 1'b0, 1'b1, 16'd1);

    // T4: narrow store merge and extension
    do_reset();
    do_store(32'd96, 32'h11223344, 2'b10);
    do_store(32'd97, 32'h000000AB, 2'b00);
    chk_status("t4", 1'b0, 1'b0, 1'b0, 16'd2);
    do_read("t4_word", 32'd96, 2'b10, 1'b0, 32'h1122AB44);
    do_read("t4_sbyte", 32'd97, 2'b00, 1'b0, 32'hFFFFFFAB);
    do_read("t4_ubyte", 32'd97, 2'b00, 1'b1, 32'h000000AB);
    do_read("t4_shalf_lo", 32'd96, 2'b01, 1'b0, 32'hFFFFAB44);
    do_read("t4_uhalf_lo", 32'd96, 2'b01, 1'b1, 32'h0000AB44);
    do_read("t4_shalf_hi", 32'd98, 2'b01, 1'b0, 32'h00001122);
    do_store(32'd98, 32'h0000BEEF, 2'b01);
    chk_status("t4h", 1'b0, 1'b0, 1'b0, 16'd3);
    do_read("t4_halfmerge", 32'd96, 2'b10, 1'b0, 32'hBEEFAB44);

    // Byte store to pass word: written, then FAIL
    do_reset();
    do_store(32'd100, 32'h00000077, 2'b00);
    chk_status("pbyte", 1'b1, 1'b0, 1'b0, 16'd1);
    do_read("pbyte_rd", 32'd100, 2'b10, 1'b0, 32'h00000077);

    // T5: in-range other address writes; out-of-range never wraps
    do_reset();
    do_store(32'd0, 32'h00000055, 2'b10);
    chk_status("t5a", 1'b1, 1'b0, 1'b0, 16'd1);
    do_reset();
    do_store(32'd256, 32'd1, 2'b10);
    chk_status("t5b", 1'b1, 1'b0, 1'b0, 16'd1);
    do_read("t5_rd0", 32'd0, 2'b10, 1'b0, 32'h00000055);
    do_read("t5_rd256", 32'd256, 2'b10, 1'b0, 32'd0);

    // T6: asynchronous reset in PASS, then reset held across a store edge
    do_reset();
    do_store(32'd100, 32'd25, 2'b10);
    chk_status("t6a", 1'b1, 1'b1, 1'b0, 16'd1);
    #2;
    reset = 1'b0;
    #1;
    $display("async reset mid-cycle");
    chk_status("t6b", 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    MemWrite    = 1'b1;
    DataAddress = 32'd96;
    WriteData   = 32'h0000AAAA;
    AccessSize  = 2'b10;
    @(posedge clk);
    #1;
    chk_status("t6c", 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    MemWrite = 1'b0;
    reset    = 1'b1;
    do_read("t6_nowrite96", 32'd96, 2'b10, 1'b0, 32'hBEEFAB44);
    do_store(32'd100, 32'd25, 2'b10);
    chk_status("t6d", 1'b1, 1'b1, 1'b0, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
